// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Micro-sequencer for a small 8-bit accumulator CPU. It walks through
//   FETCH0 -> FETCH1 -> FETCH2 -> DECODE -> EXEC(step 0..5). At the end of an
//   instruction it returns to FETCH0. Opcode 0xF0 parks the sequencer in HALT.
//   Every output is a flop loaded from the decode of the *next* {state, step}.
//   As a result, the outputs always show a clean Moore decode of the current
//   {state, step}.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_run            fetch enable; sampled only while idle in FETCH0
//   i_ir[7:0]        instruction register from the datapath (sampled in DECODE)
//   o_transfer_cmd   register-transfer command (0 = none)
//   o_inc_pc         PC increment
//   o_inc_dec_sp     01 = SP+1, 10 = SP-1, 00 = hold
//   o_alu_calculate  latch ALU result R and the C/Z flags
//   o_alu_res_to_ap  ALU operand/destination is AP instead of A
//   o_reset_ir       clear IR
//   o_next_instr     one-cycle pulse on the last step of an instruction
//   o_halted         sequencer is in HALT
//   o_illegal        sticky undefined-opcode flag
//   o_busy           high except in idle FETCH0 and HALT
// ---------------------------------------------------------------------------
module control_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic [7:0] i_ir,
  output logic [3:0] o_transfer_cmd,
  output logic       o_inc_pc,
  output logic [1:0] o_inc_dec_sp,
  output logic       o_alu_calculate,
  output logic       o_alu_res_to_ap,
  output logic       o_reset_ir,
  output logic       o_next_instr,
  output logic       o_halted,
  output logic       o_illegal,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic       inc_pc;
    logic [1:0] sp;
    logic       alu;
    logic       ap;
    logic       reset_ir;
    logic       next_instr;
    logic       halted;
    logic       busy;
  } ctl_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic       inc_pc;
    logic [1:0] sp;
    logic       alu;
    logic       ap;
    logic       last;
  } exec_t;

  // ALU opcodes that take an operand from memory (bit3 selects indirect).
  function automatic logic is_alu_mem(input logic [7:0] op);
    return (op[7:4] == 4'h3) || (op[7:4] == 4'h6) ||
           (op[7:4] == 4'h7) || (op[7:4] == 4'h8);
  endfunction

  // Register-only ALU opcodes.
  function automatic logic is_alu_reg(input logic [7:0] op);
    return (op[7:4] == 4'h5) || (op[7:4] == 4'h9);
  endfunction

  // Opcodes whose first two EXEC steps are the operand fetch pair.
  function automatic logic uses_opf(input logic [7:0] op);
    return (op == 8'h11) || (op == 8'h13) || (op == 8'h19) || (op == 8'h1B) ||
           (op == 8'h21) || (op == 8'h23) || (op == 8'hA1) || (op == 8'hA5) ||
           (op == 8'hA9) || is_alu_mem(op);
  endfunction

  function automatic logic op_legal(input logic [7:0] op);
    return (op == 8'h00) || uses_opf(op) || is_alu_reg(op) ||
           (op == 8'h2C) || (op == 8'h2E) || (op == 8'h1C) || (op == 8'h1E) ||
           (op == 8'hC0) || (op == 8'hD0) || (op == 8'hE0);
  endfunction

  // EXEC micro-step table. An undefined opcode falls through to the NOP row.
  // A default branch marks the final step, so no opcode can run past it.
  function automatic exec_t exec_decode(input logic [7:0] op, input logic [2:0] step);
    exec_t d;
    d    = '0;
    d.ap = (is_alu_mem(op) || is_alu_reg(op)) & op[1];
    if (uses_opf(op) && (step < 3'd2)) begin
      d.cmd    = (step == 3'd0) ? 4'h1 : 4'h2;
      d.inc_pc = (step == 3'd1);
    end else if ((op == 8'h11) || (op == 8'h13)) begin
      d.cmd  = 4'h5;
      d.last = 1'b1;
    end else if ((op == 8'h19) || (op == 8'h1B)) begin
      case (step)
        3'd2:    d.cmd = 4'h4;
        3'd3:    d.cmd = 4'h2;
        default: begin d.cmd = 4'h5; d.last = 1'b1; end
      endcase
    end else if ((op == 8'h21) || (op == 8'h23)) begin
      case (step)
        3'd2:    d.cmd = 4'h4;
        3'd3:    d.cmd = 4'h8;
        default: begin d.cmd = 4'h9; d.last = 1'b1; end
      endcase
    end else if ((op == 8'h2C) || (op == 8'h2E)) begin
      case (step)
        3'd0:    d.cmd = 4'h7;
        3'd1:    d.cmd = 4'h8;
        default: begin d.cmd = 4'h9; d.sp = 2'b10; d.last = 1'b1; end
      endcase
    end else if ((op == 8'h1C) || (op == 8'h1E)) begin
      case (step)
        3'd0:    d.sp  = 2'b01;
        3'd1:    d.cmd = 4'h7;
        3'd2:    d.cmd = 4'h2;
        default: begin d.cmd = 4'h5; d.last = 1'b1; end
      endcase
    end else if (is_alu_mem(op) && !op[3]) begin
      case (step)
        3'd2:    d.alu = 1'b1;
        default: begin d.cmd = 4'hA; d.last = 1'b1; end
      endcase
    end else if (is_alu_mem(op)) begin
      case (step)
        3'd2:    d.cmd = 4'h4;
        3'd3:    d.cmd = 4'h2;
        3'd4:    d.alu = 1'b1;
        default: begin d.cmd = 4'hA; d.last = 1'b1; end
      endcase
    end else if (is_alu_reg(op)) begin
      case (step)
        3'd0:    d.alu = 1'b1;
        default: begin d.cmd = 4'hA; d.last = 1'b1; end
      endcase
    end else if ((op == 8'hA1) || (op == 8'hA5) || (op == 8'hA9)) begin
      d.cmd  = 4'hB;
      d.last = 1'b1;
    end else if (op == 8'hC0) begin
      d.cmd  = 4'hC;
      d.last = 1'b1;
    end else if (op == 8'hD0) begin
      d.cmd  = 4'hD;
      d.last = 1'b1;
    end else if (op == 8'hE0) begin
      d.cmd  = 4'hE;
      d.last = 1'b1;
    end else begin
      d.last = 1'b1;
    end
    return d;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [2:0] r_step, w_step_nxt;
  logic [7:0] r_opcode, w_opcode_nxt;
  logic       r_illegal, w_set_illegal;
  ctl_t       r_ctl, w_ctl_nxt;
  exec_t      w_exec_nxt;

  assign w_exec_nxt = exec_decode(w_opcode_nxt, w_step_nxt);

  // FETCH0 uses step 0 as "idle" and step 1 as "fetch granted". Thanks to this
  // split, the fetch decision is part of {state, step}, and the outputs stay
  // pure Moore decodes.
  // In EXEC, r_ctl.next_instr already holds the "last step" flag for the
  // current step, so the table does not have to be decoded a second time.
  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_opcode_nxt  = r_opcode;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH0: begin
        if (r_step == 3'd0) begin
          if (i_run) w_step_nxt = 3'd1;
        end else begin
          w_state_nxt = S_FETCH1;
          w_step_nxt  = 3'd0;
        end
      end
      S_FETCH1: w_state_nxt = S_FETCH2;
      S_FETCH2: w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_opcode_nxt = i_ir;
        w_step_nxt   = 3'd0;
        if (i_ir == 8'hF0) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt   = S_EXEC;
          w_set_illegal = !op_legal(i_ir);
        end
      end
      S_EXEC: begin
        if (r_ctl.next_instr) begin
          w_state_nxt = S_FETCH0;
          w_step_nxt  = 3'd0;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: begin
        w_state_nxt = S_FETCH0;
        w_step_nxt  = 3'd0;
      end
    endcase
  end

  // Output decode of the next {state, step}; it is registered below.
  always_comb begin
    w_ctl_nxt = '0;
    case (w_state_nxt)
      S_FETCH0: begin
        w_ctl_nxt.reset_ir = 1'b1;
        if (w_step_nxt != 3'd0) begin
          w_ctl_nxt.cmd  = 4'h1;
          w_ctl_nxt.busy = 1'b1;
        end
      end
      S_FETCH1: begin
        w_ctl_nxt.cmd    = 4'h2;
        w_ctl_nxt.inc_pc = 1'b1;
        w_ctl_nxt.busy   = 1'b1;
      end
      S_FETCH2: begin
        w_ctl_nxt.cmd  = 4'h3;
        w_ctl_nxt.busy = 1'b1;
      end
      S_DECODE: w_ctl_nxt.busy = 1'b1;
      S_EXEC: begin
        w_ctl_nxt.cmd        = w_exec_nxt.cmd;
        w_ctl_nxt.inc_pc     = w_exec_nxt.inc_pc;
        w_ctl_nxt.sp         = w_exec_nxt.sp;
        w_ctl_nxt.alu        = w_exec_nxt.alu;
        w_ctl_nxt.ap         = w_exec_nxt.ap;
        w_ctl_nxt.next_instr = w_exec_nxt.last;
        w_ctl_nxt.busy       = 1'b1;
      end
      S_HALT: w_ctl_nxt.halted = 1'b1;
      default: w_ctl_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH0;
      r_step    <= '0;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_ctl     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_opcode  <= w_opcode_nxt;
      r_illegal <= r_illegal | w_set_illegal;
      r_ctl     <= w_ctl_nxt;
    end
  end

  assign o_transfer_cmd  = r_ctl.cmd;
  assign o_inc_pc        = r_ctl.inc_pc;
  assign o_inc_dec_sp    = r_ctl.sp;
  assign o_alu_calculate = r_ctl.alu;
  assign o_alu_res_to_ap = r_ctl.ap;
  assign o_reset_ir      = r_ctl.reset_ir;
  assign o_next_instr    = r_ctl.next_instr;
  assign o_halted        = r_ctl.halted;
  assign o_illegal       = r_illegal;
  assign o_busy          = r_ctl.busy;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. Each instruction is written as a
//   micro-op string with one token per EXEC step. A hex digit is the transfer
//   command, and suffixes add side effects: p = PC+1, u = SP+1, d = SP-1,
//   c = ALU calculate. The expected per-cycle outputs are built from that
//   string and compared with the DUT on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       i_clk;
  logic       i_rst;
  logic       i_run;
  logic [7:0] i_ir;
  logic [3:0] o_transfer_cmd;
  logic       o_inc_pc;
  logic [1:0] o_inc_dec_sp;
  logic       o_alu_calculate;
  logic       o_alu_res_to_ap;
  logic       o_reset_ir;
  logic       o_next_instr;
  logic       o_halted;
  logic       o_illegal;
  logic       o_busy;

  control_unit dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_run           (i_run),
    .i_ir            (i_ir),
    .o_transfer_cmd  (o_transfer_cmd),
    .o_inc_pc        (o_inc_pc),
    .o_inc_dec_sp    (o_inc_dec_sp),
    .o_alu_calculate (o_alu_calculate),
    .o_alu_res_to_ap (o_alu_res_to_ap),
    .o_reset_ir      (o_reset_ir),
    .o_next_instr    (o_next_instr),
    .o_halted        (o_halted),
    .o_illegal       (o_illegal),
    .o_busy          (o_busy)
  );

  typedef struct packed {
    logic [3:0] cmd;
    logic       pc;
    logic [1:0] sp;
    logic       alu;
    logic       ap;
    logic       rir;
    logic       nxt;
    logic       hlt;
    logic       ill;
    logic       busy;
  } outv_t;

  outv_t obs;
  assign obs = {o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
                o_alu_res_to_ap, o_reset_ir, o_next_instr, o_halted,
                o_illegal, o_busy};

  outv_t exp_q[$];
  logic  m_ill;
  int    total;
  int    bad;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic is_alu(input logic [7:0] op);
    logic [3:0] hi;
    hi = op[7:4];
    return (hi == 4'h3) || (hi == 4'h5) || (hi == 4'h6) ||
           (hi == 4'h7) || (hi == 4'h8) || (hi == 4'h9);
  endfunction

  // Empty string = undefined opcode.
  function automatic string micro(input logic [7:0] op);
    logic [3:0] hi;
    hi = op[7:4];
    case (op)
      8'h00:                return "0";
      8'h11, 8'h13:         return "1 2p 5";
      8'h19, 8'h1B:         return "1 2p 4 2 5";
      8'h21, 8'h23:         return "1 2p 4 8 9";
      8'h2C, 8'h2E:         return "7 8 9d";
      8'h1C, 8'h1E:         return "0u 7 2 5";
      8'hA1, 8'hA5, 8'hA9:  return "1 2p B";
      8'hC0:                return "C";
      8'hD0:                return "D";
      8'hE0:                return "E";
      default:              ;
    endcase
    if ((hi == 4'h3) || (hi == 4'h6) || (hi == 4'h7) || (hi == 4'h8))
      return op[3] ? "1 2p 4 2 0c A" : "1 2p 0c A";
    if ((hi == 4'h5) || (hi == 4'h9))
      return "0c A";
    return "";
  endfunction

  // Queue the expected cycles from the granted FETCH0 cycle through to the
  // idle FETCH0 cycle that follows completion. For 0xF0 the queue stops at
  // DECODE.
  task automatic build(input logic [7:0] op);
    outv_t      v;
    string      s;
    logic       have;
    logic [7:0] c;
    v = '0; v.ill = m_ill; v.busy = 1'b1; v.rir = 1'b1; v.cmd = 4'h1;
    exp_q.push_back(v);
    v = '0; v.ill = m_ill; v.busy = 1'b1; v.cmd = 4'h2; v.pc = 1'b1;
    exp_q.push_back(v);
    v.cmd = 4'h3; v.pc = 1'b0;
    exp_q.push_back(v);
    v.cmd = 4'h0;
    exp_q.push_back(v);
    if (op == 8'hF0) return;
    s = micro(op);
    if (s.len() == 0) begin
      m_ill = 1'b1;
      s = "0";
    end
    have = 1'b0;
    v = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46)) begin
        if (have) exp_q.push_back(v);
        v = '0; v.busy = 1'b1; v.ill = m_ill; v.ap = is_alu(op) & op[1];
        v.cmd = (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
        have = 1'b1;
      end else if (c == 8'h70) v.pc  = 1'b1;
      else if (c == 8'h75)     v.sp  = 2'b01;
      else if (c == 8'h64)     v.sp  = 2'b10;
      else if (c == 8'h63)     v.alu = 1'b1;
    end
    v.nxt = 1'b1;
    exp_q.push_back(v);
    v = '0; v.rir = 1'b1; v.ill = m_ill;
    exp_q.push_back(v);
  endtask

  // Call at the falling edge of an idle FETCH0 cycle.
  task automatic start_instr(input logic [7:0] op);
    i_run = 1'b1;
    i_ir  = op;
    build(op);
  endtask

  function automatic outv_t idle_v();
    outv_t v;
    v = '0; v.rir = 1'b1; v.ill = m_ill;
    return v;
  endfunction

  task automatic test_reset();
    outv_t e;
    i_rst = 1'b1; i_run = 1'b0; i_ir = 8'h00; m_ill = 1'b0;
    repeat (2) @(negedge i_clk);
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 14'h0);
    end
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      e = idle_v();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL idle_no_run cyc=%0d got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_fetch_exec();
    logic [7:0] ops[14];
    outv_t      e;
    ops = '{8'h11, 8'h3A, 8'h2C, 8'h1C, 8'h19, 8'h21, 8'hA5,
            8'hC0, 8'hD0, 8'hE0, 8'h00, 8'h52, 8'h93, 8'h67};
    foreach (ops[k]) begin
      start_instr(ops[k]);
      while (exp_q.size() > 0) begin
        @(negedge i_clk);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL fetch_exec op=%h got=%h want=%h", ops[k], obs, e);
        end
      end
    end
  endtask

  task automatic test_run_drop();
    outv_t e;
    int    idx;
    start_instr(8'h19);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge i_clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL run_drop idx=%0d got=%h want=%h", idx, obs, e);
      end
      if (idx == 5) i_run = 1'b0;
      idx++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      e = idle_v();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL run_drop_wait cyc=%0d got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] ops[3];
    outv_t      e;
    ops = '{8'h47, 8'h11, 8'hB3};
    foreach (ops[k]) begin
      start_instr(ops[k]);
      while (exp_q.size() > 0) begin
        @(negedge i_clk);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL illegal op=%h got=%h want=%h", ops[k], obs, e);
        end
      end
    end
    i_rst = 1'b1; i_run = 1'b0;
    @(negedge i_clk);
    m_ill = 1'b0;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL illegal_reset got=%h want=%h", obs, 14'h0);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    e = idle_v();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL illegal_cleared got=%h want=%h", obs, e);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[22];
    logic [7:0] op;
    outv_t      e;
    pool = '{8'h00, 8'h11, 8'h13, 8'h19, 8'h1B, 8'h21, 8'h23, 8'h2C,
             8'h2E, 8'h1C, 8'h1E, 8'h30, 8'h6B, 8'h72, 8'h8E, 8'h55,
             8'h9A, 8'hA1, 8'hA9, 8'hC0, 8'hD0, 8'hE0};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) op = pool[$urandom_range(0, 21)];
      else                           op = 8'($urandom);
      if (op == 8'hF0) op = 8'h00;
      start_instr(op);
      while (exp_q.size() > 0) begin
        @(negedge i_clk);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL random n=%0d op=%h got=%h want=%h", n, op, obs, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    outv_t e;
    int    cut;
    m_ill = 1'b1;
    start_instr(8'h47);
    while (exp_q.size() > 0) begin
      @(negedge i_clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_mid_pre got=%h want=%h", obs, e);
      end
    end
    cut = $urandom_range(4, 8);
    start_instr(8'h21);
    for (int i = 0; i < cut; i++) begin
      @(negedge i_clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_mid_run idx=%0d got=%h want=%h", i, obs, e);
      end
    end
    exp_q.delete();
    i_rst = 1'b1;
    @(negedge i_clk);
    m_ill = 1'b0;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_mid_zero got=%h want=%h", obs, 14'h0);
    end
    i_rst = 1'b0; i_run = 1'b0;
    @(negedge i_clk);
    e = idle_v();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_mid_idle got=%h want=%h", obs, e);
    end
  endtask

  task automatic test_halt();
    outv_t e;
    start_instr(8'hF0);
    while (exp_q.size() > 0) begin
      @(negedge i_clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL halt_fetch got=%h want=%h", obs, e);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      e = '0; e.hlt = 1'b1; e.ill = m_ill;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL halt_hold cyc=%0d got=%h want=%h", i, obs, e);
      end
      i_run = 1'($urandom_range(0, 1));
      i_ir  = 8'($urandom);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    m_ill = 1'b0;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL halt_reset got=%h want=%h", obs, 14'h0);
    end
    i_rst = 1'b0; i_run = 1'b0;
    @(negedge i_clk);
    e = idle_v();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL halt_exit got=%h want=%h", obs, e);
    end
    start_instr(8'h13);
    while (exp_q.size() > 0) begin
      @(negedge i_clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL halt_resume got=%h want=%h", obs, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_ill = 1'b0;
    i_rst = 1'b1;
    i_run = 1'b0;
    i_ir  = 8'h00;
    test_reset();
    test_fetch_exec();
    test_run_drop();
    test_illegal();
    test_random();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use these ports: i_clk in 1, rising-edge clock; i_rst in 1, synchronous active-high reset.
REQ-002 i_run in 1 SHALL mean that fetching a new instruction is allowed; it is sampled only in state FETCH0.
REQ-003 i_ir in 8 SHALL carry the instruction register value from the datapath.
REQ-004 o_transfer_cmd out 4 SHALL carry the datapath register-transfer command, where 0 means no transfer.
REQ-005 o_inc_pc out 1 SHALL increment PC in the same cycle it is high.
REQ-006 o_inc_dec_sp out 2 SHALL encode 01 = SP+1, 10 = SP-1, 00 = hold.
REQ-007 o_alu_calculate out 1 SHALL latch R and the C/Z flags.
REQ-008 o_alu_res_to_ap out 1 SHALL select AP instead of A as the ALU operand and destination.
REQ-009 o_reset_ir out 1 SHALL clear IR.
REQ-010 o_next_instr out 1 SHALL pulse for one cycle when an instruction completes.
REQ-011 o_halted out 1 SHALL be high while the FSM is in HALT.
REQ-012 o_illegal out 1 SHALL be a sticky flag set on an undefined opcode.
REQ-013 o_busy out 1 SHALL be high in every state except FETCH0-idle and HALT.

Function
REQ-014 All outputs SHALL be registered Moore decodes of {state, step}, with every output 0 in any state/step not listed below.
REQ-015 The FSM SHALL have states FETCH0, FETCH1, FETCH2, DECODE, EXEC and HALT; EXEC SHALL carry a 3-bit step counter 0..5 that resets to 0 on EXEC entry.
REQ-016 FETCH0 SHALL issue o_reset_ir=1; if i_run=1 it SHALL also issue cmd=1 (MA<=PC) and go to FETCH1, otherwise it SHALL stay in FETCH0 with cmd=0 and o_busy=0.
REQ-017 FETCH1 SHALL issue cmd=2 and o_inc_pc=1, then go to FETCH2.
REQ-018 FETCH2 SHALL issue cmd=3 (IR<=MD), then go to DECODE.
REQ-019 DECODE SHALL sample i_ir, latch the opcode internally for the rest of the instruction, and go to EXEC step 0; opcode 0xF0 SHALL go to HALT instead.
REQ-020 Operand fetch (OPF) SHALL mean step n: cmd=1, step n+1: cmd=2 with o_inc_pc=1.
REQ-021 Opcode 0x00 (NOP) SHALL complete at step 0 with no command.
REQ-022 Opcodes 0x11 and 0x13 SHALL run OPF, then cmd=5 at step 2.
REQ-023 Opcodes 0x19 and 0x1B SHALL run OPF, then cmd=4, cmd=2 and cmd=5 at steps 2..4.
REQ-024 Opcodes 0x21 and 0x23 SHALL run OPF, then cmd=4, cmd=8 and cmd=9 at steps 2..4.
REQ-025 Opcodes 0x2C and 0x2E (push) SHALL run cmd=7, cmd=8, then cmd=9 with o_inc_dec_sp=10 at steps 0..2.
REQ-026 Opcodes 0x1C and 0x1E (pop) SHALL run o_inc_dec_sp=01, then cmd=7, cmd=2 and cmd=5 at steps 0..3.
REQ-027 ALU opcodes 0x3x, 0x6x, 0x7x and 0x8x with bit3=0 SHALL run OPF, o_alu_calculate at step 2, then cmd=A at step 3.
REQ-028 ALU opcodes 0x3x, 0x6x, 0x7x and 0x8x with bit3=1 SHALL run OPF, cmd=4, cmd=2, o_alu_calculate at step 4, then cmd=A at step 5.
REQ-029 Opcodes 0x5x and 0x9x SHALL run o_alu_calculate at step 0, then cmd=A at step 1.
REQ-030 o_alu_res_to_ap SHALL equal opcode bit1 during every EXEC step of an ALU opcode and SHALL be 0 otherwise.
REQ-031 Opcodes 0xA1, 0xA5 and 0xA9 SHALL run OPF, then cmd=B at step 2; the operand SHALL always be consumed, so PC advances past it whether or not the branch is taken.
REQ-032 Opcodes 0xC0, 0xD0 and 0xE0 SHALL issue cmd=C, cmd=D and cmd=E respectively at step 0.
REQ-033 Any other opcode SHALL set o_illegal and complete as NOP.
REQ-034 On the last step of every instruction, the block SHALL assert o_next_instr for that cycle and go to FETCH0.
REQ-035 HALT SHALL be absorbing: all commands 0, o_halted=1, exited only by i_rst.
REQ-036 i_run going low mid-instruction SHALL NOT stall execution; the current instruction SHALL finish and the FSM SHALL wait in FETCH0.
REQ-037 At most one of o_inc_pc and an SP change SHALL be active in any cycle.

Reset
REQ-038 While i_rst=1 at a rising edge, the FSM SHALL enter FETCH0 with step=0, clear the opcode latch and o_illegal, and drive o_halted=0 with all other outputs 0 on the next cycle, including when reset arrives mid-instruction or in HALT.

Verification
REQ-039 Reset, then i_run=1 with i_ir=0x11: cmd sequence 1,2,3,0(DECODE),1,2,5, o_inc_pc high in cycles 2 and 6, o_next_instr in cycle 7.
REQ-040 i_ir=0x3A: steps give cmd 1,2,4,2,0,A, o_alu_calculate at step 4, o_alu_res_to_ap=1 across steps 0..5.
REQ-041 i_ir=0x2C then 0x1C: push issues 7,8,9 with SP-1 on the 9 cycle; pop issues SP+1 first, then 7,2,5.
REQ-042 i_ir=0x47: o_illegal rises after DECODE, NOP timing (o_next_instr at EXEC step 0), flag stays set until i_rst.
REQ-043 i_ir=0xF0: o_halted=1 and cmd=0 for 20 cycles regardless of i_run; i_rst=1 returns to FETCH0 with o_halted=0.
REQ-044 i_run=0 from reset: FSM holds FETCH0, o_busy=0, o_reset_ir=1, cmd=0; deasserting i_run at EXEC step 1 of 0x19 still completes through cmd=5.
